// File: rtl/load_extend_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_extend_unit_pkg                                             |
// | Shared size encodings and dword sequencing state for load format. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package load_extend_unit_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DW_HI = 1'b1
   } fsmState_t;

   function automatic logic isDword(input logic [1:0] dataSize);
      return dataSize == SZ_DWORD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend_unit_extract_ext.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_extend_unit_extract_ext                                     |
// | Lane select, ARM word rotate and sign/zero extend (combinational).|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module load_extend_unit_extract_ext
   import load_extend_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] D,
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        dataSize,
   input  logic              sign,
   output logic [DATA_W-1:0] value,
   output logic              misalign
);

   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_lane;
   logic [31:0]       w_rot;
   logic [DATA_W-1:0] w_wordExt;

   assign w_byte = D[{off, 3'b000} +: 8];
   // Halfword index ignores off[0]; a set off[0] is reported as misaligned.
   assign w_half = D[{off[OFF_W-1:1], 4'b0000} +: 16];

   generate
      if (DATA_W == 64) begin : g_lane64
         assign w_lane    = off[OFF_W-1] ? D[DATA_W-1 -: 32] : D[31:0];
         assign w_wordExt = {{(DATA_W-32){sign & w_rot[31]}}, w_rot};
      end else begin : g_lane32
         assign w_lane    = D[31:0];
         assign w_wordExt = w_rot;
      end
   endgenerate

   always_comb begin
      w_rot = w_lane;
      case (off[1:0])
         2'd1:    w_rot = {w_lane[7:0],  w_lane[31:8]};
         2'd2:    w_rot = {w_lane[15:0], w_lane[31:16]};
         2'd3:    w_rot = {w_lane[23:0], w_lane[31:24]};
         default: w_rot = w_lane;
      endcase
   end

   always_comb begin
      value    = '0;
      misalign = 1'b0;
      case (dataSize)
         SZ_BYTE: value = {{(DATA_W-8){sign & w_byte[7]}}, w_byte};
         SZ_HALF: begin
            value    = {{(DATA_W-16){sign & w_half[15]}}, w_half};
            misalign = off[0];
         end
         SZ_WORD: value = w_wordExt;
         default: begin
            value    = D;
            misalign = (off != '0);
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_extend_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | load_extend_unit                                                 |
// | Handshaked load formatter: output register, dword FSM, err count.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module load_extend_unit
   import load_extend_unit_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int CNT_W  = 16,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] D,
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        dataSize,
   input  logic              sign,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Q,
   output logic              out_last,
   output logic              out_err,
   output logic [CNT_W-1:0]  err_count
);

   localparam bit c_SPLIT_DW = (DATA_W == 32);

   fsmState_t         r_state;
   fsmState_t         w_stateNext;
   logic              r_errPend;
   logic              w_errPendNext;
   logic              w_accept;
   logic              w_misalign;
   logic              w_err;
   logic              w_last;
   logic              w_firstErr;
   logic [DATA_W-1:0] w_value;
   logic [DATA_W-1:0] w_qNext;

   load_extend_unit_extract_ext #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_extract (
      .D        (D),
      .off      (off),
      .dataSize (dataSize),
      .sign     (sign),
      .value    (w_value),
      .misalign (w_misalign)
   );

   assign in_ready = ~out_valid | out_ready;
   assign w_accept = in_valid & in_ready & ~flush;

   always_comb begin
      w_stateNext   = r_state;
      w_errPendNext = r_errPend;
      w_err         = w_misalign;
      w_last        = 1'b1;
      w_firstErr    = 1'b0;
      if (r_state == DW_HI) begin
         // High word: only the pending error from the low beat matters.
         w_err = r_errPend;
         if (w_accept) begin
            w_stateNext   = IDLE;
            w_errPendNext = 1'b0;
         end
      end else begin
         w_firstErr = w_misalign;
         if (c_SPLIT_DW && isDword(dataSize)) begin
            w_last = 1'b0;
            if (w_accept) begin
               w_stateNext   = DW_HI;
               w_errPendNext = w_misalign;
            end
         end
      end
      if (flush) begin
         w_stateNext   = IDLE;
         w_errPendNext = 1'b0;
      end
      if (w_err) begin
         w_qNext = '0;
      end else if (r_state == DW_HI) begin
         w_qNext = D;
      end else begin
         w_qNext = w_value;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state   <= IDLE;
         r_errPend <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_errPend <= w_errPendNext;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         out_valid <= 1'b0;
         Q         <= '0;
         out_last  <= 1'b0;
         out_err   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (w_accept) begin
         out_valid <= 1'b1;
         Q         <= w_qNext;
         out_last  <= w_last;
         out_err   <= w_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         err_count <= '0;
      end else if (w_accept && w_firstErr && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_extend_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_load_extend_unit                                              |
// | Vector table, directed corner sequences and random scoreboard.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_load_extend_unit;

   typedef struct {
      bit          v;
      logic [63:0] d;
      int          off;
      int          sz;
      bit          sg;
      bit          ordy;
      bit          fl;
   } stim_t;

   typedef struct {
      bit          valid;
      logic [63:0] q;
      bit          last;
      bit          err;
      bit          hi;
      bit          pend;
      int unsigned cnt;
   } mdl_t;

   typedef struct {
      int          w;
      logic [63:0] d;
      int          off;
      int          sz;
      bit          sg;
      logic [63:0] q;
      bit          err;
      bit          last;
      int unsigned cnt;
   } vec_t;

   localparam logic [63:0] M32    = 64'h0000_0000_FFFF_FFFF;
   localparam int unsigned CMAX32 = 65535;
   localparam int unsigned CMAX64 = 15;

   logic        clk = 1'b0;
   logic        CLR;
   logic        fl32, iv32, ir32, sg32, ov32, ordy32, last32, err32;
   logic [31:0] d32, q32;
   logic [1:0]  off32, sz32;
   logic [15:0] cnt32;
   logic        fl64, iv64, ir64, sg64, ov64, ordy64, last64, err64;
   logic [63:0] d64, q64;
   logic [2:0]  off64;
   logic [1:0]  sz64;
   logic [3:0]  cnt64;

   int   checks = 0;
   int   errors = 0;
   mdl_t m32, m64;

   always #5 clk = ~clk;

   load_extend_unit #(.DATA_W(32), .CNT_W(16)) dut32 (
      .CLK(clk), .CLR(CLR), .flush(fl32), .in_valid(iv32), .in_ready(ir32),
      .D(d32), .off(off32), .dataSize(sz32), .sign(sg32), .out_valid(ov32),
      .out_ready(ordy32), .Q(q32), .out_last(last32), .out_err(err32), .err_count(cnt32)
   );

   load_extend_unit #(.DATA_W(64), .CNT_W(4)) dut64 (
      .CLK(clk), .CLR(CLR), .flush(fl64), .in_valid(iv64), .in_ready(ir64),
      .D(d64), .off(off64), .dataSize(sz64), .sign(sg64), .out_valid(ov64),
      .out_ready(ordy64), .Q(q64), .out_last(last64), .out_err(err64), .err_count(cnt64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic stim_t mk(input bit v, input logic [63:0] d, input int off, input int sz,
                                input bit sg, input bit ordy, input bit fl);
      stim_t s;
      s.v = v; s.d = d; s.off = off; s.sz = sz; s.sg = sg; s.ordy = ordy; s.fl = fl;
      return s;
   endfunction

   function automatic stim_t idle();
      return mk(1'b0, 64'd0, 0, 0, 1'b0, 1'b1, 1'b0);
   endfunction

   // Extend the low 'bits' of v to the datapath width.
   function automatic logic [63:0] ext(input logic [63:0] v, input int bits, input bit sg, input int w);
      logic [63:0] r;
      r = v;
      if (sg && v[bits-1]) r = v | ~((64'd1 << bits) - 64'd1);
      if (w == 32) r = r & M32;
      return r;
   endfunction

   function automatic void modelStep(input int w, inout mdl_t m, input stim_t s, output bit rdy);
      logic [63:0] d, q, lane, rot;
      bit          err, last, first;
      int          r;
      int unsigned cmax;
      d    = (w == 32) ? (s.d & M32) : s.d;
      cmax = (w == 32) ? CMAX32 : CMAX64;
      rdy  = !m.valid || s.ordy;
      if (s.fl) begin
         m.valid = 1'b0; m.hi = 1'b0; m.pend = 1'b0;
      end else if (s.v && rdy) begin
         q = '0; err = 1'b0; last = 1'b1; first = !m.hi;
         if (m.hi) begin
            err = m.pend; q = d; m.hi = 1'b0; m.pend = 1'b0;
         end else begin
            case (s.sz)
               0: q = ext((d >> (8 * s.off)) & 64'hFF, 8, s.sg, w);
               1: begin
                  if (s.off % 2 != 0) err = 1'b1;
                  else q = ext((d >> (8 * s.off)) & 64'hFFFF, 16, s.sg, w);
               end
               2: begin
                  lane = (d >> (32 * (s.off / 4))) & M32;
                  r    = 8 * (s.off % 4);
                  rot  = ((lane >> r) | (lane << (32 - r))) & M32;
                  q    = ext(rot, 32, s.sg, w);
               end
               default: begin
                  q   = d;
                  err = (s.off != 0);
                  if (w == 32) begin
                     last = 1'b0; m.hi = 1'b1; m.pend = err;
                  end
               end
            endcase
         end
         if (err) q = '0;
         if (first && err && m.cnt < cmax) m.cnt = m.cnt + 1;
         m.valid = 1'b1; m.q = q; m.err = err; m.last = last;
      end else if (s.ordy) begin
         m.valid = 1'b0;
      end
   endfunction

   task automatic drive(input stim_t a, input stim_t b);
      iv32 = a.v; d32 = a.d[31:0]; off32 = 2'(a.off); sz32 = 2'(a.sz);
      sg32 = a.sg; ordy32 = a.ordy; fl32 = a.fl;
      iv64 = b.v; d64 = b.d; off64 = 3'(b.off); sz64 = 2'(b.sz);
      sg64 = b.sg; ordy64 = b.ordy; fl64 = b.fl;
   endtask

   task automatic readOut(input int w, output logic v, output logic [63:0] q,
                          output logic l, output logic e, output int unsigned c);
      if (w == 32) begin
         v = ov32; q = {32'd0, q32}; l = last32; e = err32; c = cnt32;
      end else begin
         v = ov64; q = q64; l = last64; e = err64; c = cnt64;
      end
   endtask

   task automatic checkOut(input int w, input mdl_t m);
      logic v, l, e;
      logic [63:0] q;
      int unsigned c;
      readOut(w, v, q, l, e, c);
      chk($sformatf("out_valid%0d", w), v, m.valid);
      if (m.valid) begin
         chk($sformatf("Q%0d", w), q, m.q);
         chk($sformatf("out_last%0d", w), l, m.last);
         chk($sformatf("out_err%0d", w), e, m.err);
      end
      chk($sformatf("err_count%0d", w), c, m.cnt);
   endtask

   // One clock: drive at posedge+1, check in_ready, advance model, check outputs at next posedge+1.
   task automatic cycle(input stim_t a, input stim_t b);
      bit ra, rb;
      drive(a, b);
      #1;
      modelStep(32, m32, a, ra);
      modelStep(64, m64, b, rb);
      chk("in_ready32", ir32, ra);
      chk("in_ready64", ir64, rb);
      @(posedge clk);
      #1;
      checkOut(32, m32);
      checkOut(64, m64);
   endtask

   task automatic resetModels();
      m32 = '{default: 0};
      m64 = '{default: 0};
   endtask

   initial begin
      vec_t        tbl[16];
      stim_t       sa, sb;
      logic        v, l, e;
      logic [63:0] q;
      int unsigned c;

      CLR = 1'b0;
      drive(idle(), idle());
      resetModels();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid32", ov32, 1'b0);
      chk("rst_Q32", q32, 32'd0);
      chk("rst_out_last32", last32, 1'b0);
      chk("rst_out_err32", err32, 1'b0);
      chk("rst_err_count32", cnt32, 16'd0);
      chk("rst_in_ready32", ir32, 1'b1);
      chk("rst_out_valid64", ov64, 1'b0);
      chk("rst_Q64", q64, 64'd0);
      chk("rst_err_count64", cnt64, 4'd0);
      chk("rst_in_ready64", ir64, 1'b1);
      CLR = 1'b1;

      tbl[0]  = '{32, 64'h0000FF03, 0, 0, 1'b1, 64'h00000003, 1'b0, 1'b1, 0};
      tbl[1]  = '{32, 64'h0000FF03, 1, 0, 1'b1, 64'hFFFFFFFF, 1'b0, 1'b1, 0};
      tbl[2]  = '{32, 64'h0000FF03, 1, 0, 1'b0, 64'h000000FF, 1'b0, 1'b1, 0};
      tbl[3]  = '{32, 64'hF0E47492, 2, 1, 1'b1, 64'hFFFFF0E4, 1'b0, 1'b1, 0};
      tbl[4]  = '{32, 64'hF0E47492, 1, 1, 1'b1, 64'h00000000, 1'b1, 1'b1, 1};
      tbl[5]  = '{32, 64'hF0E47492, 1, 2, 1'b0, 64'h92F0E474, 1'b0, 1'b1, 1};
      tbl[6]  = '{32, 64'h11111111, 0, 3, 1'b0, 64'h11111111, 1'b0, 1'b0, 1};
      tbl[7]  = '{32, 64'h22222222, 0, 0, 1'b1, 64'h22222222, 1'b0, 1'b1, 1};
      tbl[8]  = '{32, 64'h33333333, 2, 3, 1'b0, 64'h00000000, 1'b1, 1'b0, 2};
      tbl[9]  = '{32, 64'h44444444, 1, 0, 1'b1, 64'h00000000, 1'b1, 1'b1, 2};
      tbl[10] = '{64, 64'h8877665544332211, 0, 3, 1'b1, 64'h8877665544332211, 1'b0, 1'b1, 0};
      tbl[11] = '{64, 64'h8877665544332211, 6, 2, 1'b0, 64'h0000000066558877, 1'b0, 1'b1, 0};
      tbl[12] = '{64, 64'h8877665544332211, 4, 2, 1'b1, 64'hFFFFFFFF88776655, 1'b0, 1'b1, 0};
      tbl[13] = '{64, 64'h8877665544332211, 3, 3, 1'b0, 64'h0000000000000000, 1'b1, 1'b1, 1};
      tbl[14] = '{64, 64'h8877665544332211, 7, 0, 1'b1, 64'hFFFFFFFFFFFFFF88, 1'b0, 1'b1, 1};
      tbl[15] = '{64, 64'h8877665544332211, 6, 1, 1'b0, 64'h0000000000008877, 1'b0, 1'b1, 1};

      for (int i = 0; i < 16; i++) begin
         sa = mk(1'b1, tbl[i].d, tbl[i].off, tbl[i].sz, tbl[i].sg, 1'b1, 1'b0);
         if (tbl[i].w == 32) cycle(sa, idle());
         else cycle(idle(), sa);
         readOut(tbl[i].w, v, q, l, e, c);
         chk($sformatf("vec%0d_valid", i), v, 1'b1);
         chk($sformatf("vec%0d_Q", i), q, tbl[i].q);
         chk($sformatf("vec%0d_err", i), e, tbl[i].err);
         chk($sformatf("vec%0d_last", i), l, tbl[i].last);
         chk($sformatf("vec%0d_cnt", i), c, tbl[i].cnt);
      end

      // Backpressure: beat B waits three cycles behind A, then drains in order.
      cycle(mk(1'b1, 64'hA5A5A5A5, 0, 2, 1'b0, 1'b1, 1'b0), idle());
      for (int i = 0; i < 3; i++) begin
         cycle(mk(1'b1, 64'h5A5A5A5A, 0, 2, 1'b0, 1'b0, 1'b0), idle());
         chk("stall_Q", q32, 32'hA5A5A5A5);
         chk("stall_in_ready", ir32, 1'b0);
      end
      cycle(mk(1'b1, 64'h5A5A5A5A, 0, 2, 1'b0, 1'b1, 1'b0), idle());
      chk("release_Q_B", q32, 32'h5A5A5A5A);
      cycle(mk(1'b1, 64'hC3C3C3C3, 0, 2, 1'b0, 1'b1, 1'b0), idle());
      chk("release_Q_C", q32, 32'hC3C3C3C3);
      chk("release_valid_C", ov32, 1'b1);
      cycle(idle(), idle());
      chk("drain_valid", ov32, 1'b0);

      // Flush while waiting for the high word, then a byte decoded from IDLE.
      cycle(mk(1'b1, 64'hDEADBEEF, 0, 3, 1'b0, 1'b1, 1'b0), idle());
      chk("dw_lo_last", last32, 1'b0);
      cycle(mk(1'b1, 64'h12345678, 0, 0, 1'b0, 1'b1, 1'b1), idle());
      chk("flush_valid", ov32, 1'b0);
      cycle(mk(1'b1, 64'h00000080, 0, 0, 1'b1, 1'b1, 1'b0), idle());
      chk("post_flush_Q", q32, 32'hFFFFFF80);
      chk("post_flush_last", last32, 1'b1);

      // Saturation of the 4-bit counter on the 64-bit instance.
      for (int i = 0; i < 20; i++) begin
         cycle(idle(), mk(1'b1, {$urandom(), $urandom()}, 1, 1, 1'b0, 1'b1, 1'b0));
      end
      chk("cnt64_saturated", cnt64, 4'hF);

      // Asynchronous reset in the middle of a dword access.
      cycle(mk(1'b1, 64'h11111111, 0, 3, 1'b0, 1'b1, 1'b0),
            mk(1'b1, 64'h0123456789ABCDEF, 0, 3, 1'b0, 1'b1, 1'b0));
      CLR = 1'b0;
      #1;
      chk("aclr_valid32", ov32, 1'b0);
      chk("aclr_Q32", q32, 32'd0);
      chk("aclr_last32", last32, 1'b0);
      chk("aclr_cnt32", cnt32, 16'd0);
      chk("aclr_valid64", ov64, 1'b0);
      chk("aclr_Q64", q64, 64'd0);
      chk("aclr_cnt64", cnt64, 4'd0);
      #2;
      CLR = 1'b1;
      resetModels();
      cycle(mk(1'b1, 64'h0000FF03, 1, 0, 1'b0, 1'b1, 1'b0), idle());
      chk("post_aclr_Q", q32, 32'h000000FF);
      chk("post_aclr_last", last32, 1'b1);

      // Random traffic with random backpressure and occasional flush.
      for (int i = 0; i < 600; i++) begin
         sa = mk(1'($urandom_range(0, 3) != 0), {32'd0, $urandom()}, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
         sb = mk(1'($urandom_range(0, 3) != 0), {$urandom(), $urandom()}, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
         cycle(sa, sb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_extend_unit.md
# load_extend_unit

Parametrised, handshaked load-data formatter for the ARM datapath. It accepts raw memory-read words and extracts byte, halfword, word or doubleword elements at a byte offset, with optional sign extension. Misaligned words use the ARM rotate behaviour, misaligned halfwords and doublewords are flagged, and doublewords are split into two beats when needed. It sits between the data-memory read port and the register-file write-back path, replacing the fixed single-register sign extender.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- CNT_W, 16, width of the saturating error counter.
- OFF_W, derived log2(DATA_W/8), byte-offset width; not overridable.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- D  in  DATA_W  raw memory word.
- off  in  OFF_W  byte offset of the element within D.
- dataSize  in  2  element size: 00 byte, 01 half, 10 word, 11 dword.
- sign  in  1  1 = sign-extend, 0 = zero-extend.
- out_valid  out  1  Q valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- Q  out  DATA_W  formatted result.
- out_last  out  1  final beat of the access.
- out_err  out  1  alignment error on this beat.
- err_count  out  CNT_W  count of erroneous accesses; saturating.

## Operation
- Single output register stage. in_ready = ~out_valid | out_ready.
- Byte: Q = ext(D[8*off +: 8]).
- Half:
  - Legal only if off[0]=0.
  - Q = ext(D[8*off +: 16]).
  - If misaligned: Q=0, out_err=1.
- Word:
  - The lane is the 32-bit lane at offset off & ~3.
  - Q = ext(rotr(lane, 8*(off&3))).
  - A misaligned word is not an error.
  - ext with a 32-bit element on DATA_W=32 is the identity.
- Dword, DATA_W=64:
  - Single beat, Q = D, out_last=1.
  - off≠0 → Q=0, out_err=1.
- Dword, DATA_W=32: two-beat FSM.
  - IDLE: on accepting a dword beat, Q=D, out_last=0, go to DW_HI, and latch err_pend = (off≠0).
  - DW_HI: the next accepted beat is the high word. Its dataSize, off and sign are ignored. Q=D, out_last=1, out_err=err_pend, then return to IDLE.
  - If err_pend is set, both beats have Q=0 and out_err=1.
- out_last=1 for every non-dword beat. sign is ignored for dword beats.
- err_count increments once per erroneous access, on the first beat. It holds at all-ones.
- flush:
  - Clears out_valid, returns the FSM to IDLE and clears err_pend.
  - A beat presented in the same cycle is discarded.
  - err_count is unaffected.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: one beat per cycle when out_ready=1.
- Reset values (CLR=0):
  - out_valid=0, Q=0, out_last=0, out_err=0.
  - FSM=IDLE, err_pend=0, err_count=0.
  - in_ready=1 after reset.
- Stall: with out_valid=1 & out_ready=0, Q, out_last and out_err hold, and in_ready=0.
- Simultaneous output pop and input accept in the same cycle: the new beat replaces the register with no bubble.
- flush has priority over accept and over pop.
- Reset asserted mid-dword (in DW_HI) aborts the access. The next beat is decoded from IDLE.
- Counter increment and saturation take effect in the accept cycle and are visible the next cycle.

## Structure
- Shared package, datapath-wide:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - FSM state enum (IDLE, DW_HI).
- Sub-module extract_ext: combinational lane select, rotate and sign/zero extend. Inputs D, off, dataSize, sign; outputs the value and the misalign flag.
- Top level holds the handshake, output register, FSM, err_pend and err_count.

## Test plan
- DATA_W=32, D=32'h0000FF03:
  - byte, off=0, sign=1 → Q=32'h00000003.
  - off=1, sign=1 → 32'hFFFFFFFF.
  - off=1, sign=0 → 32'h000000FF.
  - All out_last=1, out_err=0.
- D=32'hF0E47492:
  - half, off=2, sign=1 → 32'hFFFFF0E4.
  - half, off=1 → Q=0, out_err=1, err_count=1.
  - word, off=1 → 32'h92F0E474, out_err=0.
- Dword on DATA_W=32:
  - Beats 32'h11111111 then 32'h22222222, off=0 → two outputs with out_last 0 then 1.
  - Repeat with off=2 → both beats out_err=1, Q=0, err_count +1 only.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → Q stable, in_ready=0, no beat lost.
  - Release → strict in-order output at 1 beat per cycle.
- flush in DW_HI, then a byte beat → decoded as byte from IDLE. Async CLR mid-stream → all outputs zero immediately.
- DATA_W=64:
  - dword, off=0 → single beat, Q=D, out_last=1.
  - word, off=6, D=64'h8877665544332211 → Q=64'h0000000066558877 with sign=0.
  - Force err_count to saturate → it holds at all-ones.
